regfile_mp: RTL and testbench

Parametrised multi-read-port register file and successor to the fixed 16x8 two-port regfile used in the playground datapaths. It adds configurable width, depth and read-port count, per-byte write enables, and optional write-to-read bypass. It adds an optional hardwired-zero entry and a sequential clear engine that zeroes the array after reset or on request, with a busy/ready handshake. Storage maps to distributed RAM (ram_style = "distributed"), one write port and N_RD asynchronous read ports.

---
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_mp: multi-read-port register file with byte enables, bypass,     |
// | optional hardwired-zero entry and a sequential clear engine.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int N_RD     = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     clr,
    output logic                     busy,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [DATA_W/8-1:0]      w_be,
    input  logic [N_RD*ADDR_W-1:0]   r_addr,
    output logic [N_RD*DATA_W-1:0]   r_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int N_BE  = DATA_W / 8;

    // CLEAR is the all-zero encoding so an unconfigured device powers up sweeping.
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_ptr;

    (* ram_style = "distributed" *)
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_discard;
    logic [DATA_W-1:0]   w_merged;

    assign busy      = (r_state == S_CLEAR);
    assign w_ready   = ~busy;
    assign w_accept  = w_valid & w_ready & rst_n;
    assign w_discard = (ZERO_REG != 0) && (w_addr == '0);

    always_comb begin
        w_merged = r_mem[w_addr];
        for (int i = 0; i < N_BE; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    if (&r_clr_ptr) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (clr) begin
                        r_state   <= S_CLEAR;
                        r_clr_ptr <= '0;
                    end
                end
                default: begin
                    r_state   <= S_CLEAR;
                    r_clr_ptr <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_n) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_accept && !w_discard) begin
                r_mem[w_addr] <= w_merged;
            end
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = r_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem[w_ra];
            if ((BYPASS != 0) && w_accept && (w_ra == w_addr)) begin
                w_rd = w_merged;
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign r_data[p*DATA_W +: DATA_W] = w_rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// Scoreboard bench: two instances (bypass+zero-reg, plain) driven in lockstep
// against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NR    = 3;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 16;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic              rst_n   = 1'b0;
    logic              clr     = 1'b0;
    logic              w_valid = 1'b0;
    logic [AW-1:0]     w_addr  = '0;
    logic [DW-1:0]     w_data  = '0;
    logic [NB-1:0]     w_be    = '0;
    logic [NR*AW-1:0]  r_addr  = '0;

    logic              busy_bz, ready_bz, busy_pl, ready_pl;
    logic [NR*DW-1:0]  rd_bz, rd_pl;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(1), .ZERO_REG(1)) u_dut_bz (
        .clk_in(clk_in), .rst_n(rst_n), .clr(clr), .busy(busy_bz),
        .w_valid(w_valid), .w_ready(ready_bz), .w_addr(w_addr), .w_data(w_data),
        .w_be(w_be), .r_addr(r_addr), .r_data(rd_bz)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(0), .ZERO_REG(0)) u_dut_pl (
        .clk_in(clk_in), .rst_n(rst_n), .clr(clr), .busy(busy_pl),
        .w_valid(w_valid), .w_ready(ready_pl), .w_addr(w_addr), .w_data(w_data),
        .w_be(w_be), .r_addr(r_addr), .r_data(rd_pl)
    );

    typedef struct {
        logic [NR*DW-1:0] rd_bz;
        logic [NR*DW-1:0] rd_pl;
        logic             busy;
        int               id;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            n_items = 0;

    // Reference model: plain arrays plus "sweep in progress" bookkeeping.
    logic [DW-1:0] m_bz [DEPTH];
    logic [DW-1:0] m_pl [DEPTH];
    bit            m_busy = 1'b1;
    int            m_pos  = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [NR*AW-1:0] ra3(input int a0, input int a1, input int a2);
        return {AW'(a2 % DEPTH), AW'(a1 % DEPTH), AW'(a0 % DEPTH)};
    endfunction

    function automatic logic [NR*AW-1:0] rand_ra(input logic [AW-1:0] wa);
        logic [NR*AW-1:0] r;
        for (int p = 0; p < NR; p++) begin
            r[p*AW +: AW] = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom);
        end
        return r;
    endfunction

    task automatic drive(input logic rst, input logic c, input logic wv,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NB-1:0] be, input logic [NR*AW-1:0] ra);
        exp_t          e;
        logic          acc;
        logic [AW-1:0] a;
        @(negedge clk_in);
        rst_n = rst; clr = c; w_valid = wv; w_addr = wa;
        w_data = wd; w_be = be; r_addr = ra;

        acc = wv && !m_busy && rst;
        for (int p = 0; p < NR; p++) begin
            a = ra[p*AW +: AW];
            e.rd_pl[p*DW +: DW] = m_pl[a];
            if (a == 0)
                e.rd_bz[p*DW +: DW] = '0;
            else if (acc && a == wa)
                e.rd_bz[p*DW +: DW] = merge(m_bz[a], wd, be);
            else
                e.rd_bz[p*DW +: DW] = m_bz[a];
        end
        e.busy = m_busy;
        e.id   = n_items;
        n_items++;
        sb.push_back(e);

        // Apply the effect of the coming rising edge.
        if (!rst) begin
            m_busy = 1'b1;
            m_pos  = 0;
        end else if (m_busy) begin
            m_bz[m_pos] = '0;
            m_pl[m_pos] = '0;
            m_pos++;
            if (m_pos == DEPTH) m_busy = 1'b0;
        end else begin
            if (wv) begin
                if (wa != 0) m_bz[wa] = merge(m_bz[wa], wd, be);
                m_pl[wa] = merge(m_pl[wa], wd, be);
            end
            if (c) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, '0, ra3(3*i, 3*i+1, 3*i+2));
        end
    endtask

    // Monitor: samples mid-low-phase, well away from the rising edge.
    initial begin
        exp_t e;
        logic [3:0] got_hs, exp_hs;
        forever begin
            @(negedge clk_in);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (rd_bz !== e.rd_bz) begin
                    errors++;
                    $display("FAIL rdata_bypass_zero item=%0d got=%h exp=%h", e.id, rd_bz, e.rd_bz);
                end
                checks++;
                if (rd_pl !== e.rd_pl) begin
                    errors++;
                    $display("FAIL rdata_plain item=%0d got=%h exp=%h", e.id, rd_pl, e.rd_pl);
                end
                checks++;
                got_hs = {busy_bz, ready_bz, busy_pl, ready_pl};
                exp_hs = {e.busy, !e.busy, e.busy, !e.busy};
                if (got_hs !== exp_hs) begin
                    errors++;
                    $display("FAIL busy_ready item=%0d got=%b exp=%b", e.id, got_hs, exp_hs);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_bz[i] = '0;
            m_pl[i] = '0;
        end
        @(posedge clk_in);

        // Reset held 3 cycles with write attempts, then the post-reset sweep.
        repeat (3) drive(1'b0, 1'b0, 1'b1, AW'($urandom), $urandom, 4'hF, rand_ra('0));
        repeat (16) drive(1'b1, 1'b1, 1'b1, AW'($urandom), $urandom, 4'hF, ra3(0, 15, 8));
        read_all();

        // Byte-enable merge, then a be=0 no-op.
        drive(1'b1, 1'b0, 1'b1, 4'd5, 32'h11223344, 4'hF,    ra3(5, 5, 5));
        drive(1'b1, 1'b0, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, ra3(5, 5, 5));
        drive(1'b1, 1'b0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h0,    ra3(5, 5, 5));
        drive(1'b1, 1'b0, 1'b0, 4'd0, '0,           4'h0,    ra3(5, 5, 5));

        // Multi-port bypass: ports reading 2, 2 and 7 during a write to 2.
        drive(1'b1, 1'b0, 1'b1, 4'd7, 32'h12345678, 4'hF, ra3(2, 2, 7));
        drive(1'b1, 1'b0, 1'b1, 4'd2, 32'h0000005A, 4'hF, ra3(2, 2, 7));
        drive(1'b1, 1'b0, 1'b0, 4'd0, '0,           4'h0, ra3(2, 2, 7));

        // Zero register.
        drive(1'b1, 1'b0, 1'b1, 4'd0, 32'h000000FF, 4'hF, ra3(0, 0, 0));
        drive(1'b1, 1'b0, 1'b0, 4'd0, '0,           4'h0, ra3(0, 0, 0));

        // Clear request with simultaneous write, mid-sweep clr pulses.
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, 1'b0, 1'b1, AW'(i), 32'hC3C3C3C3, 4'hF, ra3(i, i, 9));
        drive(1'b1, 1'b1, 1'b1, 4'd9, 32'h00000077, 4'hF, ra3(9, 9, 9));
        for (int i = 0; i < 16; i++)
            drive(1'b1, (i % 4) == 2, 1'b1, 4'd9, 32'h00000077, 4'hF, ra3(9, i, 0));
        read_all();

        // Reset mid-clear at sweep position 10.
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, 1'b0, 1'b1, AW'(i), $urandom, 4'hF, rand_ra(AW'(i)));
        drive(1'b1, 1'b1, 1'b0, '0, '0, '0, ra3(1, 2, 3));
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b0, 1'b0, '0, '0, '0, ra3(i, 11, 15));
        drive(1'b0, 1'b0, 1'b1, 4'd3, $urandom, 4'hF, ra3(3, 11, 15));
        repeat (16) drive(1'b1, 1'b0, 1'b1, 4'd3, $urandom, 4'hF, ra3(3, 11, 15));
        read_all();

        // Randomised traffic with occasional clear requests and resets.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom);
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) != 0, wa, $urandom, NB'($urandom), rand_ra(wa));
        end

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk_in);
        @(negedge clk_in);
        #4;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
